reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 40 ++++
 rtl/reg_file_rdport.sv | 29 ++
 rtl/reg_file.sv | 83 ++++++++
 tb/tb_reg_file.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared definitions for the register file and the control unit that feeds it:
// register-index constants, datapath widths, the stack-pointer reset value and
// the write-register selection mux encodings.
package reg_file_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    // Architectural register indices with fixed roles.
    localparam logic [REG_ADDR_W-1:0] ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] SP   = 5'd29;
    localparam logic [REG_ADDR_W-1:0] RA   = 5'd31;

    localparam int unsigned SP_RESET_DEFAULT = 227;

    // Destination-register selection used by the control unit's write mux.
    typedef enum logic [1:0] {
        WSEL_RT = 2'd0,  // I-type: destination from the rt field
        WSEL_RD = 2'd1,  // R-type: destination from the rd field
        WSEL_RA = 2'd2   // jump-and-link: destination is the return address
    } wr_sel_e;

    // Reference implementation of the write-register mux shared with the control unit.
    function automatic logic [REG_ADDR_W-1:0] sel_write_reg(
        input wr_sel_e               sel,
        input logic [REG_ADDR_W-1:0] rt,
        input logic [REG_ADDR_W-1:0] rd
    );
        logic [REG_ADDR_W-1:0] dst;
        dst = rt;
        case (sel)
            WSEL_RT: dst = rt;
            WSEL_RD: dst = rd;
            WSEL_RA: dst = RA;
            default: dst = rt;
        endcase
        return dst;
    endfunction

endpackage

// File: rtl/reg_file_rdport.sv
// One combinational read port: forces register 0 to read as zero and, when
// built with REGFILE_BYPASS_EN, forwards same-cycle write data to the reader.
module reg_file_rdport
    import reg_file_pkg::*;
(
`ifdef REGFILE_BYPASS_EN
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
`endif
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0]     stored,
    output logic [DATA_W-1:0]     rd_data
);

    // Select between hard-wired zero, forwarded write data and stored contents.
    always_comb begin
        rd_data = stored;
`ifdef REGFILE_BYPASS_EN
        // Forwarding is skipped during reset because that write will be dropped.
        if (!reset && wr_en && (wr_addr != ZERO) && (wr_addr == rd_addr))
            rd_data = wr_data;
`endif
        if (rd_addr == ZERO)
            rd_data = '0;
    end

endmodule

// File: rtl/reg_file.sv
// Register file with two asynchronous read ports, one synchronous write port,
// synchronous active-high reset (register 29 resets to SP_RESET) and write
// tracking outputs. Optional macro: REGFILE_BYPASS_EN enables write-through
// forwarding on both read ports.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int          NREGS    = 32,
    parameter int unsigned SP_RESET = SP_RESET_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0]     write_data,
    input  logic [REG_ADDR_W-1:0] read_reg1,
    input  logic [REG_ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0]     read_data1,
    output logic [DATA_W-1:0]     read_data2,
    output logic [REG_ADDR_W-1:0] last_wr_addr,
    output logic                  last_wr_valid,
    output logic [15:0]           wr_count
);

    logic [DATA_W-1:0] regs [NREGS];
    logic              commit;

    // A write only takes effect when enabled and not aimed at the zero register.
    assign commit = reg_write && (write_reg != ZERO);

    // Register array update; reset clears everything except the stack pointer.
    // NOTE: this array is reset explicitly because the architecture defines every
    // register's value after reset; that forces flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= (i == int'(SP)) ? DATA_W'(SP_RESET) : '0;
        end else if (commit) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            regs[write_reg] <= write_data;
        end
    end

    // Write-tracking outputs: last address, one-cycle valid pulse, wrapping count.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_wr_addr  <= ZERO;
            last_wr_valid <= 1'b0;
            wr_count      <= '0;
        end else begin
            last_wr_valid <= commit;
            if (commit) begin
                last_wr_addr <= write_reg;
                wr_count     <= wr_count + 16'd1;
            end
        end
    end

    reg_file_rdport u_rdport_a (
`ifdef REGFILE_BYPASS_EN
        .reset   (reset),
        .wr_en   (reg_write),
        .wr_addr (write_reg),
        .wr_data (write_data),
`endif
        .rd_addr (read_reg1),
        .stored  (regs[read_reg1]),
        .rd_data (read_data1)
    );

    reg_file_rdport u_rdport_b (
`ifdef REGFILE_BYPASS_EN
        .reset   (reset),
        .wr_en   (reg_write),
        .wr_addr (write_reg),
        .wr_data (write_data),
`endif
        .rd_addr (read_reg2),
        .stored  (regs[read_reg2]),
        .rd_data (read_data2)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset contents, write/read,
// zero register, same-cycle read of the write target, reset priority and
// write-counter wrap.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [4:0]  last_wr_addr;
    logic        last_wr_valid;
    logic [15:0] wr_count;

    int n_cmp = 0;
    int n_mis = 0;

    reg_file dut (
        .clk           (clk),
        .reset         (reset),
        .reg_write     (reg_write),
        .write_reg     (write_reg),
        .write_data    (write_data),
        .read_reg1     (read_reg1),
        .read_reg2     (read_reg2),
        .read_data1    (read_data1),
        .read_data2    (read_data2),
        .last_wr_addr  (last_wr_addr),
        .last_wr_valid (last_wr_valid),
        .wr_count      (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_same;
        logic [4:0]  a;
        logic [31:0] d;

        reset      = 1'b1;
        reg_write  = 1'b0;
        write_reg  = 5'd0;
        write_data = 32'd0;
        read_reg1  = 5'd0;
        read_reg2  = 5'd0;
        tick();
        reset = 1'b0;

        // Reset contents: all zero except the stack pointer.
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i);
            read_reg2 = 5'(31 - i);
            #1;
            check($sformatf("reset_rd1_r%0d", i), read_data1, (i == 29) ? 32'd227 : 32'd0);
            check($sformatf("reset_rd2_r%0d", 31 - i), read_data2, ((31 - i) == 29) ? 32'd227 : 32'd0);
        end
        check("reset_wr_count", 32'(wr_count), 32'd0);
        check("reset_last_valid", 32'(last_wr_valid), 32'd0);
        check("reset_last_addr", 32'(last_wr_addr), 32'd0);

        // Basic write then read.
        reg_write = 1'b1; write_reg = 5'd8; write_data = 32'hDEADBEEF;
        tick();
        reg_write = 1'b0; read_reg1 = 5'd8; read_reg2 = 5'd8;
        #1;
        check("wr8_rd1", read_data1, 32'hDEADBEEF);
        check("wr8_rd2", read_data2, 32'hDEADBEEF);
        check("wr8_last_addr", 32'(last_wr_addr), 32'd8);
        check("wr8_last_valid", 32'(last_wr_valid), 32'd1);
        check("wr8_count", 32'(wr_count), 32'd1);
        tick();
        check("wr8_valid_drop", 32'(last_wr_valid), 32'd0);
        check("wr8_addr_hold", 32'(last_wr_addr), 32'd8);

        // Write to register 0 is discarded.
        reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h12345678; read_reg1 = 5'd0;
        #1;
        check("r0_bypass_never", read_data1, 32'd0);
        tick();
        reg_write = 1'b0; read_reg2 = 5'd0;
        #1;
        check("r0_rd2", read_data2, 32'd0);
        check("r0_count", 32'(wr_count), 32'd1);
        check("r0_valid", 32'(last_wr_valid), 32'd0);
        check("r0_addr_hold", 32'(last_wr_addr), 32'd8);

        // Same-cycle read of the write target.
        reg_write = 1'b1; write_reg = 5'd5; write_data = 32'h1;
        tick();
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'hA5;
`else
        exp_same = 32'h1;
`endif
        write_data = 32'hA5; read_reg1 = 5'd5; read_reg2 = 5'd5;
        #1;
        check("same_cycle_rd1", read_data1, exp_same);
        check("same_cycle_rd2", read_data2, exp_same);
        tick();
        reg_write = 1'b0;
        #1;
        check("after_edge_rd1", read_data1, 32'hA5);
        check("after_edge_count", 32'(wr_count), 32'd3);

        // Back-to-back writes to one address: later value wins, both count.
        reg_write = 1'b1; write_reg = 5'd7; write_data = 32'h11;
        tick();
        write_data = 32'h22;
        tick();
        reg_write = 1'b0; read_reg1 = 5'd7;
        #1;
        check("b2b_rd1", read_data1, 32'h22);
        check("b2b_count", 32'(wr_count), 32'd5);
        check("b2b_last_addr", 32'(last_wr_addr), 32'd7);

        // Reset beats a simultaneous write; no forwarding while in reset.
        reset = 1'b1; reg_write = 1'b1; write_reg = 5'd29; write_data = 32'hFF;
        read_reg1 = 5'd29; read_reg2 = 5'd8;
        #1;
        check("rst_no_bypass", read_data1, 32'd227);
        check("rst_pre_edge_r8", read_data2, 32'hDEADBEEF);
        tick();
        reset = 1'b0; reg_write = 1'b0;
        #1;
        check("rst_r29", read_data1, 32'd227);
        check("rst_r8_cleared", read_data2, 32'd0);
        check("rst_count", 32'(wr_count), 32'd0);
        check("rst_valid", 32'(last_wr_valid), 32'd0);
        check("rst_last_addr", 32'(last_wr_addr), 32'd0);

        // Counter wrap: 65536 committed writes across registers 1..31.
        reg_write = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            write_reg  = 5'((i % 31) + 1);
            write_data = 32'(i) ^ 32'hC0DE0000;
            tick();
            if (i == 65534)
                check("wrap_count_ffff", 32'(wr_count), 32'h0000FFFF);
        end
        reg_write = 1'b0;
        a = 5'((65535 % 31) + 1);
        d = 32'(65535) ^ 32'hC0DE0000;
        read_reg1 = a; read_reg2 = 5'd1;
        #1;
        check("wrap_count_zero", 32'(wr_count), 32'd0);
        check("wrap_last_addr", 32'(last_wr_addr), 32'(a));
        check("wrap_last_valid", 32'(last_wr_valid), 32'd1);
        check("wrap_last_data", read_data1, d);
        check("wrap_r1_data", read_data2, 32'(65534) ^ 32'hC0DE0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
